channel_sequencer: RTL
======================

# channel_sequencer

Sequencing controller for one convolution stage, sitting between the input-image RAM and a `spatial_conv_core`. It reads each channel plane from a single-port synchronous RAM. It presents words to the core one channel at a time and switches channel round-robin whenever the core asserts hold for the active channel. It also gathers the per-kernel results of the last conv stage into a single ordered stream for the fully connected layer or an output RAM.

## Interface
Parameters:
- ADDR_WIDTH, 16, RAM address width
- DATA_WIDTH, 32, word width (Q16.16 data, passed through untouched)
- N_ROWS, 28, rows per channel plane
- N_COLS, 28, columns per channel plane
- N_CHANNELS, 3, input channels; plane c starts at BASE_ADDR + c·N_ROWS·N_COLS
- N_KERNELS, 3, result lanes gathered on output
- OUTPUT_SIZE, 25, results expected per kernel lane
- BASE_ADDR, 0, address of channel 0 word 0

Ports:
- clock_i  in  1  system clock
- reset_i  in  1  asynchronous, active-high reset
- start_i  in  1  one-cycle pulse that starts a frame
- rdaddress_o  out  ADDR_WIDTH  RAM read address (combinational)
- ram_data_i  in  DATA_WIDTH  RAM q, valid one clock after its address
- data_o[N_CHANNELS]  out  DATA_WIDTH  per-channel word to the conv core
- data_valid_o[N_CHANNELS]  out  1  per-channel valid
- hold_data_i[N_CHANNELS]  in  1  per-channel backpressure from the conv core
- result_data_i[N_KERNELS]  in  DATA_WIDTH  conv results
- result_valid_i[N_KERNELS]  in  1  conv result valids
- stream_data_o  out  DATA_WIDTH  gathered result
- stream_valid_o  out  1  one-cycle strobe for stream_data_o
- busy_o  out  1  frame in progress
- done_o  out  1  frame complete (level)

## Operation
- Per-channel state: rd_ptr[c] (next address to load), loaded[c] (data_o[c] holds an unconsumed word), remaining[c] (words left to consume, initialised to N_ROWS·N_COLS).
- Consume event on channel c: data_valid_o[c] && !hold_data_i[c] at a rising edge.
- Input FSM:
  - IDLE: on start_i, initialise all pointers and counters, set curr=0, go to PRIME.
  - PRIME: rdaddress_o = rd_ptr[curr]. Next state is STREAM if loaded[curr], else FILL.
  - FILL: data_o[curr] <= ram_data_i, rd_ptr++, loaded=1. Go to STREAM.
  - STREAM: data_valid_o[curr]=loaded[curr]. On consume: remaining--. If words are left in the plane, data_o <= ram_data_i and rd_ptr++; otherwise loaded=0.
  - In STREAM, rdaddress_o = rd_ptr[curr]+consume, so ram_data_i always equals mem[rd_ptr[curr]].
  - Leaving STREAM: when hold_data_i[curr]=1, or remaining[curr] reaches 0, drop data_valid_o[curr], set curr=(curr+1) mod N_CHANNELS, go to WAIT_RELEASE.
  - WAIT_RELEASE: skip channels with remaining=0. When every remaining is 0, go to DONE. Otherwise wait until hold_data_i[curr]=0, then go to PRIME.
  - DONE: done_o=1. start_i restarts the frame, which re-initialises state and clears done_o.
- Output gather:
  - k_ptr cycles 0..N_KERNELS-1. out_left is initialised to N_KERNELS·OUTPUT_SIZE on start.
  - When result_valid_i[k_ptr] && out_left>0: stream_data_o <= result_data_i[k_ptr], stream_valid_o=1 for one cycle, k_ptr wraps, out_left--.
  - result_valid_i of non-selected lanes is ignored. The producer keeps them asserted until selected.
- busy_o = !IDLE && !done_o.
- done_o requires input FSM in DONE and out_left=0.
- start_i is ignored while busy_o=1.

## Timing
- Reset value of every output and register is 0, and the FSM is IDLE. Asynchronous reset mid-frame aborts immediately; no partial state survives.
- Latency from start_i to first data_valid_o[0]=1 is 3 edges: IDLE→PRIME→FILL→STREAM.
- Sustained throughput is 1 word/cycle per channel while not held.
- Re-entering a channel costs one PRIME bubble, plus FILL only if loaded=0.
- Hold and a consume can never coincide, because a consume requires !hold.
- A hold asserted in the same cycle that remaining reaches 0 is treated as a single switch.
- Result to stream_valid_o latency is 1 cycle. out_left saturates at 0, and extra valids are dropped.

## Configuration
- CHANNEL_SEQUENCER_GATHER_EN defined: output gather is present and done_o waits for out_left=0.
- Not defined: gather logic is removed, stream_data_o=0, stream_valid_o=0, and done_o depends only on the input FSM.

## Test plan
Every scenario uses N_ROWS=2, N_COLS=2, N_CHANNELS=2, N_KERNELS=2, OUTPUT_SIZE=2, BASE_ADDR=0, with RAM word n = n.
- Reset then start_i, hold tied 0 → channel 0 presents 0,1,2,3 on consecutive cycles starting at edge 3; then channel 1 presents 4,5,6,7 after one PRIME+FILL; done_o is 0 until 4 results are gathered.
- Hold[0] pulsed after word 1 is consumed → data_valid_o[0] drops, channel 1 streams 4.., and on return channel 0 resumes with word 2 (no duplicate, no loss).
- Hold[1] held high while switching to channel 1 → FSM stays in WAIT_RELEASE, rdaddress_o is unchanged, and PRIME follows the cycle after release.
- result_valid_i = {1,1} for 4 cycles with data {A,B} → stream emits A,B,A,B, then out_left=0, done_o=1, and a 5th valid is ignored.
- reset_i asserted mid-STREAM → all outputs 0 in the same cycle; a subsequent start_i replays from address 0.
- Macro undefined → stream_valid_o stays 0, and done_o=1 right after channel 1 word 7 is consumed.

Source files
------------

// File: rtl/channel_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : channel_sequencer                                             |
// | Description : Streams channel planes from a single-port synchronous RAM     |
// |               to a conv core, one channel at a time, switching round-robin  |
// |               on hold. It optionally gathers per-kernel results into one    |
// |               ordered output stream.                                       |
// | Option      : CHANNEL_SEQUENCER_GATHER_EN enables the output gather         |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module channel_sequencer #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int N_ROWS      = 28,
  parameter int N_COLS      = 28,
  parameter int N_CHANNELS  = 3,
  parameter int N_KERNELS   = 3,
  parameter int OUTPUT_SIZE = 25,
  parameter int BASE_ADDR   = 0
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  output logic [ADDR_WIDTH-1:0] rdaddress_o,
  input  logic [DATA_WIDTH-1:0] ram_data_i,
  output logic [DATA_WIDTH-1:0] data_o [N_CHANNELS],
  output logic [N_CHANNELS-1:0] data_valid_o,
  input  logic [N_CHANNELS-1:0] hold_data_i,
  input  logic [DATA_WIDTH-1:0] result_data_i [N_KERNELS],
  input  logic [N_KERNELS-1:0]  result_valid_i,
  output logic [DATA_WIDTH-1:0] stream_data_o,
  output logic                  stream_valid_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int PLANE = N_ROWS * N_COLS;
  localparam int CW    = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;
  localparam int RW    = $clog2(PLANE + 1);
  localparam logic [CW-1:0] LAST_CH = CW'(N_CHANNELS - 1);
  localparam logic [RW-1:0] PLANE_W = RW'(PLANE);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PRIME  = 3'd1,
    S_FILL   = 3'd2,
    S_STREAM = 3'd3,
    S_WAIT   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t                state, state_next;
  logic [CW-1:0]         curr, curr_next, curr_inc;
  logic [ADDR_WIDTH-1:0] rd_ptr    [N_CHANNELS];
  logic [RW-1:0]         remaining [N_CHANNELS];
  logic [N_CHANNELS-1:0] loaded;
  logic [N_CHANNELS-1:0] plane_empty;
  logic                  start_ok;
  logic                  init;
  logic                  fill;
  logic                  consume;

  // A new frame is accepted only when no frame is in flight.
  assign start_ok = start_i && !busy_o;
  assign busy_o   = (state != S_IDLE) && !done_o;
  assign curr_inc = (curr == LAST_CH) ? '0 : curr + CW'(1);

  // Flag channels whose plane has been fully consumed.
  always_comb begin
    for (int c = 0; c < N_CHANNELS; c++) begin
      plane_empty[c] = (remaining[c] == '0);
    end
  end

  // State and active-channel register.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state <= S_IDLE;
      curr  <= '0;
    end else begin
      state <= state_next;
      curr  <= curr_next;
    end
  end

  // Next-state, read address and per-channel valid decode.
  always_comb begin
    state_next   = state;
    curr_next    = curr;
    init         = 1'b0;
    fill         = 1'b0;
    consume      = 1'b0;
    data_valid_o = '0;
    rdaddress_o  = rd_ptr[curr];
    case (state)
      S_IDLE, S_DONE: begin
        if (start_ok) begin
          init       = 1'b1;
          curr_next  = '0;
          state_next = S_PRIME;
        end
      end
      S_PRIME: begin
        state_next = loaded[curr] ? S_STREAM : S_FILL;
      end
      S_FILL: begin
        // Look one word ahead so the RAM output lines up with the bumped pointer.
        fill        = 1'b1;
        rdaddress_o = rd_ptr[curr] + ADDR_WIDTH'(1);
        state_next  = S_STREAM;
      end
      S_STREAM: begin
        data_valid_o[curr] = loaded[curr];
        consume            = loaded[curr] && !hold_data_i[curr];
        rdaddress_o        = rd_ptr[curr] + ADDR_WIDTH'(consume);
        // Hold or the last word leaving (or both at once) is one switch.
        if (hold_data_i[curr] || (remaining[curr] == RW'(consume))) begin
          curr_next  = curr_inc;
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (&plane_empty) begin
          state_next = S_DONE;
        end else if (plane_empty[curr]) begin
          curr_next = curr_inc;
        end else if (!hold_data_i[curr]) begin
          state_next = S_PRIME;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Per-channel pointers, word counters and presented data.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      for (int c = 0; c < N_CHANNELS; c++) begin
        rd_ptr[c]    <= '0;
        remaining[c] <= '0;
        data_o[c]    <= '0;
      end
      loaded <= '0;
    end else if (init) begin
      for (int c = 0; c < N_CHANNELS; c++) begin
        rd_ptr[c]    <= ADDR_WIDTH'(BASE_ADDR + c * PLANE);
        remaining[c] <= PLANE_W;
      end
      loaded <= '0;
    end else if (fill) begin
      data_o[curr] <= ram_data_i;
      rd_ptr[curr] <= rd_ptr[curr] + ADDR_WIDTH'(1);
      loaded[curr] <= 1'b1;
    end else if (consume) begin
      remaining[curr] <= remaining[curr] - RW'(1);
      if (remaining[curr] > RW'(1)) begin
        data_o[curr] <= ram_data_i;
        rd_ptr[curr] <= rd_ptr[curr] + ADDR_WIDTH'(1);
      end else begin
        loaded[curr] <= 1'b0;
      end
    end
  end

`ifdef CHANNEL_SEQUENCER_GATHER_EN
  localparam int KW = (N_KERNELS > 1) ? $clog2(N_KERNELS) : 1;
  localparam int OW = $clog2(N_KERNELS * OUTPUT_SIZE + 1);
  localparam logic [KW-1:0] LAST_K    = KW'(N_KERNELS - 1);
  localparam logic [OW-1:0] OUT_TOTAL = OW'(N_KERNELS * OUTPUT_SIZE);

  logic [KW-1:0] k_ptr;
  logic [OW-1:0] out_left;

  // Round-robin gather of kernel results; extra valids past the total are dropped.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      k_ptr          <= '0;
      out_left       <= '0;
      stream_data_o  <= '0;
      stream_valid_o <= 1'b0;
    end else begin
      stream_valid_o <= 1'b0;
      if (start_ok) begin
        k_ptr    <= '0;
        out_left <= OUT_TOTAL;
      end else if (result_valid_i[k_ptr] && (out_left != '0)) begin
        stream_data_o  <= result_data_i[k_ptr];
        stream_valid_o <= 1'b1;
        k_ptr          <= (k_ptr == LAST_K) ? '0 : k_ptr + KW'(1);
        out_left       <= out_left - OW'(1);
      end
    end
  end

  assign done_o = (state == S_DONE) && (out_left == '0);
`else
  logic unused_results;

  // Results are not consumed when the gather is absent.
  always_comb begin
    unused_results = ^result_valid_i;
    for (int k = 0; k < N_KERNELS; k++) begin
      unused_results = unused_results ^ (^result_data_i[k]);
    end
  end

  assign stream_data_o  = '0;
  assign stream_valid_o = 1'b0;
  assign done_o         = (state == S_DONE);
`endif

endmodule
`default_nettype wire
